// File: rtl/i2s_audio_transmitter_pkg.sv
// Shared I2S framing constants and the stereo sample type used by the transmitter
// and receiver sides.
package i2s_pkg;

    localparam int i2s_frame_bits = 64;
    localparam int i2s_slot_bits  = 32;

    typedef struct packed {
        logic [31:0] left;
        logic [31:0] right;
    } i2s_stereo_t;

    // Left-justify a w-bit sample in its 32-bit slot so the MSB always leads the slot.
    function automatic logic [31:0] i2s_align(input logic [31:0] s, input int w);
        return s << (i2s_slot_bits - w);
    endfunction

endpackage

// File: rtl/i2s_audio_transmitter_if.sv
// Parallel sample-side handshake of the I2S transmitter: a stereo pair offered with
// valid/ready, plus the underrun status pulse.
interface i2s_audio_transmitter_if #(
    parameter int w_sample = 24
) ();
    logic [w_sample-1:0] left;
    logic [w_sample-1:0] right;
    logic                in_valid;
    logic                in_ready;
    logic                underrun;

    modport master (output left, output right, output in_valid, input in_ready, input underrun);
    modport slave  (input left, input right, input in_valid, output in_ready, output underrun);
endinterface

// File: rtl/i2s_audio_transmitter_sck_gen.sv
// Bit-clock divider: registered 50% duty sck plus a one-clk tick on the clock edge
// where sck goes 1->0.
module i2s_sck_gen #(
    parameter int clk_div = 16
) (
    input  logic clk,
    input  logic rst,
    output logic sck,
    output logic fall_tick
);
    localparam int             DW       = (clk_div > 1) ? $clog2(clk_div) : 1;
    localparam logic [DW-1:0]  DIV_LAST = DW'(clk_div - 1);
    localparam logic [DW-1:0]  DIV_HALF = DW'(clk_div / 2);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          sck_q, sck_d;

    // sck is registered from the next count so it lines up with div_cnt_q.
    always_comb begin
        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DW'(1);
        sck_d     = (div_cnt_d >= DIV_HALF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            sck_q     <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            sck_q     <= sck_d;
        end
    end

    assign sck       = sck_q;
    assign fall_tick = (div_cnt_q == DIV_LAST);
endmodule

// File: rtl/i2s_audio_transmitter.sv
// I2S master transmitter: serialises a single-entry holding register of stereo
// samples onto sck/ws/sd, 64 sck per frame, sending zeros on underrun.
module i2s_audio_transmitter
    import i2s_pkg::*;
#(
    parameter int clk_div  = 16,
    parameter int w_sample = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    i2s_audio_transmitter_if.slave  src,
    output logic                    sck,
    output logic                    ws,
    output logic                    sd
);
    localparam int              FB_W     = $clog2(i2s_frame_bits);
    localparam logic [FB_W-1:0] LAST_BIT = FB_W'(i2s_frame_bits - 1);

    logic fall_tick;

    i2s_sck_gen #(.clk_div(clk_div)) u_sck_gen (
        .clk       (clk),
        .rst       (rst),
        .sck       (sck),
        .fall_tick (fall_tick)
    );

    logic [FB_W-1:0]           bit_cnt_q, bit_cnt_d, ws_idx;
    logic                      ws_q, ws_d;
    logic [i2s_frame_bits-1:0] shift_q, shift_d;
    i2s_stereo_t               hold_q, hold_d;
    logic                      hold_valid_q, hold_valid_d;
    logic                      underrun_q, underrun_d;
    logic                      frame_start, accept;

    assign frame_start = fall_tick && (bit_cnt_q == LAST_BIT);
    assign accept      = src.in_valid && !hold_valid_q;

    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        ws_d         = ws_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        underrun_d   = 1'b0;
        // ws tracks the bit after the one being entered, so it leads data by one sck.
        ws_idx       = bit_cnt_q + FB_W'(2);
        if (fall_tick) begin
            bit_cnt_d = bit_cnt_q + FB_W'(1);
            ws_d      = ws_idx[FB_W-1];
            shift_d   = {shift_q[i2s_frame_bits-2:0], 1'b0};
        end
        if (frame_start) begin
            if (hold_valid_q) shift_d = hold_q;
            else              shift_d = '0;
            underrun_d   = !hold_valid_q;
            hold_valid_d = 1'b0;
        end
        // Applied after the frame-start clear so a colliding accept is kept for next frame.
        if (accept) begin
            hold_d.left  = i2s_align(32'(src.left),  w_sample);
            hold_d.right = i2s_align(32'(src.right), w_sample);
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q    <= '0;
            ws_q         <= 1'b0;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            ws_q         <= ws_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            underrun_q   <= underrun_d;
        end
    end

    assign ws           = ws_q;
    assign sd           = shift_q[i2s_frame_bits-1];
    assign src.in_ready = !hold_valid_q;
    assign src.underrun = underrun_q;
endmodule

// File: tb/tb_i2s_audio_transmitter.sv
// Directed bench for the I2S transmitter at clk_div=4; a 16- and 32-bit instance
// share the clock and reset for the width sweep.
module tb_i2s_audio_transmitter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    // Clocks since the last reset edge; frame f starts on the edge where cyc becomes 256*f.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    i2s_audio_transmitter_if #(.w_sample(24)) bus0 ();
    i2s_audio_transmitter_if #(.w_sample(16)) bus16 ();
    i2s_audio_transmitter_if #(.w_sample(32)) bus32 ();
    logic sck0, ws0, sd0, sck16, ws16, sd16, sck32, ws32, sd32;

    i2s_audio_transmitter #(.clk_div(4), .w_sample(24)) dut0 (
        .clk(clk), .rst(rst), .src(bus0.slave), .sck(sck0), .ws(ws0), .sd(sd0));
    i2s_audio_transmitter #(.clk_div(4), .w_sample(16)) dut16 (
        .clk(clk), .rst(rst), .src(bus16.slave), .sck(sck16), .ws(ws16), .sd(sd16));
    i2s_audio_transmitter #(.clk_div(4), .w_sample(32)) dut32 (
        .clk(clk), .rst(rst), .src(bus32.slave), .sck(sck32), .ws(ws32), .sd(sd32));

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Advance to 1 time unit after the edge that makes cyc == n.
    task automatic at(input int n);
        if (cyc > n) begin
            n_cmp++; n_bad++;
            $display("FAIL schedule: cyc=%0d already past required %0d", cyc, n);
        end
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Record one frame starting at edge `base`; sd words are bit 0 at [63].
    task automatic capture(input int base, output logic [63:0] s0, output logic [63:0] w0,
                           output logic [63:0] s16, output logic [63:0] s32,
                           output int viol, output int urun, output int ufirst, output int rdylo);
        logic psck, psd, pws;
        int   k;
        s0 = '0; w0 = '0; s16 = '0; s32 = '0;
        viol = 0; urun = 0; ufirst = -1; rdylo = 0;
        at(base - 1);
        psck = sck0; psd = sd0; pws = ws0;
        for (int n = base; n < base + 256; n++) begin
            at(n);
            if ((sd0 !== psd || ws0 !== pws) && !(psck === 1'b1 && sck0 === 1'b0)) viol++;
            if (bus0.underrun === 1'b1) begin
                if (urun == 0) ufirst = n - base;
                urun++;
            end
            if (bus0.in_ready !== 1'b1) rdylo++;
            if ((n - base) % 4 == 2) begin
                k = 63 - (n - base) / 4;
                s0[k] = sd0; w0[k] = ws0; s16[k] = sd16; s32[k] = sd32;
            end
            psck = sck0; psd = sd0; pws = ws0;
        end
    endtask

    task automatic test_reset();
        logic [3:0] sck_exp;
        sck_exp = 4'b0110;
        n_cmp++; if (sck0 !== 1'b0) begin n_bad++; $display("FAIL reset_sck: got %b want 0", sck0); end
        n_cmp++; if (ws0 !== 1'b0) begin n_bad++; $display("FAIL reset_ws: got %b want 0", ws0); end
        n_cmp++; if (sd0 !== 1'b0) begin n_bad++; $display("FAIL reset_sd: got %b want 0", sd0); end
        n_cmp++; if (bus0.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus0.in_ready); end
        n_cmp++; if (bus0.underrun !== 1'b0) begin n_bad++; $display("FAIL reset_underrun: got %b want 0", bus0.underrun); end
        for (int n = 1; n <= 4; n++) begin
            at(n);
            n_cmp++;
            if (sck0 !== sck_exp[n-1]) begin
                n_bad++; $display("FAIL sck_phase clk %0d: got %b want %b", n, sck0, sck_exp[n-1]);
            end
        end
        at(123); n_cmp++; if (ws0 !== 1'b0) begin n_bad++; $display("FAIL ws_bit30: got %b want 0", ws0); end
        at(124); n_cmp++; if (ws0 !== 1'b1) begin n_bad++; $display("FAIL ws_bit31: got %b want 1", ws0); end
        at(251); n_cmp++; if (ws0 !== 1'b1) begin n_bad++; $display("FAIL ws_bit62: got %b want 1", ws0); end
        at(252); n_cmp++; if (ws0 !== 1'b0) begin n_bad++; $display("FAIL ws_bit63: got %b want 0", ws0); end
        at(256); n_cmp++; if (bus0.underrun !== 1'b1) begin n_bad++; $display("FAIL first_wrap_underrun: got %b want 1", bus0.underrun); end
        // Queue a pair, then reset mid-frame: it must be discarded.
        at(260);
        bus0.left = 24'h555555; bus0.right = 24'h333333; bus0.in_valid = 1'b1;
        at(261);
        bus0.in_valid = 1'b0;
        n_cmp++; if (bus0.in_ready !== 1'b0) begin n_bad++; $display("FAIL pre_reset_ready: got %b want 0", bus0.in_ready); end
        at(402);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (sck0 !== 1'b0) begin n_bad++; $display("FAIL midreset_sck: got %b want 0", sck0); end
        n_cmp++; if (ws0 !== 1'b0) begin n_bad++; $display("FAIL midreset_ws: got %b want 0", ws0); end
        n_cmp++; if (sd0 !== 1'b0) begin n_bad++; $display("FAIL midreset_sd: got %b want 0", sd0); end
        n_cmp++; if (bus0.in_ready !== 1'b1) begin n_bad++; $display("FAIL midreset_ready: got %b want 1", bus0.in_ready); end
        rst = 1'b0;
        at(256);
        n_cmp++; if (bus0.underrun !== 1'b1) begin n_bad++; $display("FAIL discard_underrun: got %b want 1", bus0.underrun); end
    endtask

    task automatic test_single_pair();
        logic [63:0] s0, w0, s16, s32;
        int viol, urun, ufirst, rdylo;
        at(260);
        bus0.left = 24'h800001; bus0.right = 24'h7FFFFE; bus0.in_valid = 1'b1;
        at(261);
        bus0.in_valid = 1'b0;
        n_cmp++; if (bus0.in_ready !== 1'b0) begin n_bad++; $display("FAIL single_ready_fall: got %b want 0", bus0.in_ready); end
        at(511);
        n_cmp++; if (bus0.in_ready !== 1'b0) begin n_bad++; $display("FAIL single_ready_held: got %b want 0", bus0.in_ready); end
        capture(512, s0, w0, s16, s32, viol, urun, ufirst, rdylo);
        n_cmp++; if (s0 !== 64'h80000100_7FFFFE00) begin n_bad++; $display("FAIL single_sd: got %h want 800001007ffffe00", s0); end
        n_cmp++; if (w0 !== 64'h00000001_FFFFFFFE) begin n_bad++; $display("FAIL single_ws: got %h want 00000001fffffffe", w0); end
        n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL single_edge_align: got %0d off-edge changes want 0", viol); end
        n_cmp++; if (urun !== 0) begin n_bad++; $display("FAIL single_underrun: got %0d want 0", urun); end
        n_cmp++; if (rdylo !== 0) begin n_bad++; $display("FAIL single_ready_rise: got %0d low cycles want 0", rdylo); end
    endtask

    task automatic test_backpressure();
        logic [63:0] s0, w0, s16, s32;
        int viol, urun, ufirst, rdylo;
        int acc, lo, ur;
        acc = 0; lo = 0; ur = 0;
        for (int n = 776; n < 1288; n++) begin
            at(n);
            if (bus0.in_ready === 1'b1) acc++;
            else                        lo++;
            if (bus0.underrun === 1'b1) ur++;
            bus0.left = 24'h100000 + 24'(n); bus0.right = 24'h200000 + 24'(n);
            bus0.in_valid = 1'b1;
        end
        at(1288);
        bus0.in_valid = 1'b0;
        n_cmp++; if (acc !== 3) begin n_bad++; $display("FAIL bp_accepts: got %0d want 3", acc); end
        n_cmp++; if (lo !== 509) begin n_bad++; $display("FAIL bp_ready_low: got %0d want 509", lo); end
        n_cmp++; if (ur !== 0) begin n_bad++; $display("FAIL bp_underrun: got %0d want 0", ur); end
        capture(1536, s0, w0, s16, s32, viol, urun, ufirst, rdylo);
        n_cmp++; if (s0 !== 64'h10050000_20050000) begin n_bad++; $display("FAIL bp_data: got %h want 1005000020050000", s0); end
        n_cmp++; if (urun !== 0) begin n_bad++; $display("FAIL bp_frame_underrun: got %0d want 0", urun); end
    endtask

    task automatic test_underrun();
        logic [63:0] s0, w0, s16, s32;
        int viol, urun, ufirst, rdylo;
        capture(1792, s0, w0, s16, s32, viol, urun, ufirst, rdylo);
        n_cmp++; if (s0 !== 64'h0) begin n_bad++; $display("FAIL ur_sd_zero: got %h want 0", s0); end
        n_cmp++; if (urun !== 1) begin n_bad++; $display("FAIL ur_pulse_count: got %0d want 1", urun); end
        n_cmp++; if (ufirst !== 0) begin n_bad++; $display("FAIL ur_pulse_pos: got %0d want 0", ufirst); end
        capture(2048, s0, w0, s16, s32, viol, urun, ufirst, rdylo);
        n_cmp++; if (urun !== 1) begin n_bad++; $display("FAIL ur_second_frame: got %0d want 1", urun); end
        at(2310);
        bus0.left = 24'h123456; bus0.right = 24'hABCDEF; bus0.in_valid = 1'b1;
        at(2311);
        bus0.in_valid = 1'b0;
        capture(2560, s0, w0, s16, s32, viol, urun, ufirst, rdylo);
        n_cmp++; if (s0 !== 64'h12345600_ABCDEF00) begin n_bad++; $display("FAIL ur_resume_data: got %h want 12345600abcdef00", s0); end
        n_cmp++; if (urun !== 0) begin n_bad++; $display("FAIL ur_resume_underrun: got %0d want 0", urun); end
    endtask

    task automatic test_collision();
        logic [63:0] s0, w0, s16, s32;
        int viol, urun, ufirst, rdylo;
        at(2815);
        bus0.left = 24'hC0FFEE; bus0.right = 24'h00BEEF; bus0.in_valid = 1'b1;
        capture(2816, s0, w0, s16, s32, viol, urun, ufirst, rdylo);
        bus0.in_valid = 1'b0;
        n_cmp++; if (s0 !== 64'h0) begin n_bad++; $display("FAIL col_sd_zero: got %h want 0", s0); end
        n_cmp++; if (urun !== 1 || ufirst !== 0) begin n_bad++; $display("FAIL col_underrun: got %0d at %0d want 1 at 0", urun, ufirst); end
        n_cmp++; if (rdylo !== 256) begin n_bad++; $display("FAIL col_held: got %0d ready-low cycles want 256", rdylo); end
        capture(3072, s0, w0, s16, s32, viol, urun, ufirst, rdylo);
        n_cmp++; if (s0 !== 64'hC0FFEE00_00BEEF00) begin n_bad++; $display("FAIL col_data: got %h want c0ffee0000beef00", s0); end
        n_cmp++; if (urun !== 0 || rdylo !== 0) begin n_bad++; $display("FAIL col_next_frame: underrun %0d ready-low %0d want 0 0", urun, rdylo); end
    endtask

    task automatic test_width_sweep();
        logic [63:0] s0, w0, s16, s32;
        int viol, urun, ufirst, rdylo;
        at(3330);
        bus16.left = 16'hA5C3; bus16.right = 16'h1234; bus16.in_valid = 1'b1;
        bus32.left = 32'h80000001; bus32.right = 32'hFFFF0000; bus32.in_valid = 1'b1;
        at(3331);
        bus16.in_valid = 1'b0; bus32.in_valid = 1'b0;
        capture(3584, s0, w0, s16, s32, viol, urun, ufirst, rdylo);
        n_cmp++; if (s16 !== 64'hA5C30000_12340000) begin n_bad++; $display("FAIL w16_sd: got %h want a5c3000012340000", s16); end
        n_cmp++; if (s32 !== 64'h80000001_FFFF0000) begin n_bad++; $display("FAIL w32_sd: got %h want 80000001ffff0000", s32); end
        n_cmp++; if (s0 !== 64'h0) begin n_bad++; $display("FAIL w24_idle: got %h want 0", s0); end
    endtask

    initial begin
        bus0.left = '0;  bus0.right = '0;  bus0.in_valid = 1'b0;
        bus16.left = '0; bus16.right = '0; bus16.in_valid = 1'b0;
        bus32.left = '0; bus32.right = '0; bus32.in_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_single_pair();
        test_backpressure();
        test_underrun();
        test_collision();
        test_width_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
